// File: rtl/mcs4.sv
// ----------------------------------------------------------------------------
// mcs4 : shared types for the MCS-4 run controller slice.
//
//   char_t      - one 4-bit character on the MCS-4 data bus
//   addr_t      - 12-bit ROM address
//   subcycle_t  - the eight subcycles of an instruction cycle (A1..X3)
//   run_state_t - run/step controller state (exported for debug)
//
// Helper:
//   next_subcycle() - subcycle successor, wraps X3 -> A1
// ----------------------------------------------------------------------------
package mcs4;

    typedef logic [3:0]  char_t;
    typedef logic [11:0] addr_t;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } subcycle_t;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2
    } run_state_t;

    function automatic subcycle_t next_subcycle(input subcycle_t sc);
        return subcycle_t'(sc + 3'd1);
    endfunction

endpackage

// File: rtl/mcs4_run_ctrl_if.sv
// ----------------------------------------------------------------------------
// mcs4_run_ctrl_if : host control, CPU bus snoop and status of mcs4_run_ctrl.
//
// Host / bus side (driven by the master):
//   run, step, bp_en, bp_addr, bp_clr   host run control and breakpoint
//   sync, dbus                          i4004 sync line and OR-combined bus
// Controller side (driven by the slave):
//   clken_1, clken_2                    phase enables for the MCS-4 chips
//   halted, synced, subcycle            run / tracking status
//   last_addr, last_opcode, cycle_count captured fetch info
//   bp_hit, sync_err                    sticky flags
//   run_state                           controller FSM state, for debug
//
// Handshake: there is no valid/ready pair here. run and bp_en are levels;
// step and bp_clr are single-clk pulses that are acted on in the clk they
// are high; sync/dbus are only looked at in the clk where clken_2 is high.
// ----------------------------------------------------------------------------
interface mcs4_run_ctrl_if;
    import mcs4::*;

    logic       run;
    logic       step;
    logic       bp_en;
    addr_t      bp_addr;
    logic       bp_clr;
    logic       sync;
    char_t      dbus;

    logic       clken_1;
    logic       clken_2;
    logic       halted;
    logic       synced;
    subcycle_t  subcycle;
    addr_t      last_addr;
    logic [7:0] last_opcode;
    logic [31:0] cycle_count;
    logic       bp_hit;
    logic       sync_err;
    run_state_t run_state;

    modport master (
        output run, step, bp_en, bp_addr, bp_clr, sync, dbus,
        input  clken_1, clken_2, halted, synced, subcycle, last_addr,
               last_opcode, cycle_count, bp_hit, sync_err, run_state
    );

    modport slave (
        input  run, step, bp_en, bp_addr, bp_clr, sync, dbus,
        output clken_1, clken_2, halted, synced, subcycle, last_addr,
               last_opcode, cycle_count, bp_hit, sync_err, run_state
    );

endinterface

// File: rtl/mcs4_phase_gen.sv
// ----------------------------------------------------------------------------
// mcs4_phase_gen : two-phase clock-enable generator.
//
// Parameters:
//   CLK_DIV  clk cycles per phase pulse (1..255)
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   enable    count and emit pulses while high
//   restart   clear the divider so the next pulse is clken_1 CLK_DIV clk later
//   clken_1   one-clk phase-1 enable
//   clken_2   one-clk phase-2 enable
// ----------------------------------------------------------------------------
module mcs4_phase_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic clken_1,
    output logic clken_2
);

    logic [7:0] div_cnt;
    logic       phi;      // 0: next pulse is clken_1, 1: next pulse is clken_2
    logic       at_top;

    assign at_top = (div_cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= 8'd0;
            phi     <= 1'b0;
        end else if (restart) begin
            div_cnt <= 8'd0;
            phi     <= 1'b0;
        end else if (enable) begin
            if (at_top) begin
                div_cnt <= 8'd0;
                phi     <= ~phi;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    // Pulses are combinational on the counter so they vanish the moment
    // enable drops or reset asserts; no partial pulse can leak out.
    assign clken_1 = enable & at_top & ~phi;
    assign clken_2 = enable & at_top &  phi;

endmodule

// File: rtl/mcs4_run_ctrl.sv
// ----------------------------------------------------------------------------
// mcs4_run_ctrl : run/step controller and clock-enable sequencer for MCS-4.
//
// Tracks the 8-subcycle instruction cycle from the i4004 sync line, snoops
// the data bus for fetch address and opcode, and lets the host run, halt,
// single-step and (optionally) break on a ROM address. Stops happen only at
// instruction-cycle boundaries (sync sampled high at a clken_2).
//
// Parameters:
//   CLK_DIV  clk cycles per phase pulse (1..255)
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   ctl       mcs4_run_ctrl_if.slave (host control, bus snoop, status)
//
// Build option:
//   MCS4_BREAKPOINT_EN  when defined, an A3 fetch address matching bp_addr
//                       (with bp_en=1) sets bp_hit; otherwise bp_hit is 0
//                       and bp_en/bp_addr/bp_clr are ignored.
// ----------------------------------------------------------------------------
module mcs4_run_ctrl
    import mcs4::*;
#(
    parameter int CLK_DIV = 4
) (
    input logic           clk,
    input logic           rst,
    mcs4_run_ctrl_if.slave ctl
);

    run_state_t  state_q, state_d;
    logic        restart;
    logic        halted;
    logic        clken_1, clken_2;
    logic        boundary;

    logic        synced_q;
    subcycle_t   subcycle_q;
    addr_t       last_addr_q;
    logic [7:0]  last_opcode_q;
    logic [31:0] cycle_count_q;
    logic        sync_err_q;
    logic        bp_hit_q;

    assign halted   = (state_q == HALTED);
    assign boundary = clken_2 & ctl.sync;

    mcs4_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase_gen (
        .clk     (clk),
        .rst     (rst),
        .enable  (~halted),
        .restart (restart),
        .clken_1 (clken_1),
        .clken_2 (clken_2)
    );

    // ---------------- run/step FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= HALTED;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        case (state_q)
            HALTED: begin
                // run is blocked by a pending breakpoint, step is not
                if (ctl.run && !bp_hit_q) begin
                    state_d = RUN;
                    restart = 1'b1;
                end else if (ctl.step) begin
                    state_d = STEP;
                    restart = 1'b1;
                end
            end
            RUN: begin
                if (boundary && (!ctl.run || bp_hit_q)) state_d = HALTED;
            end
            STEP: begin
                if (boundary) state_d = HALTED;
            end
            default: state_d = HALTED;
        endcase
    end

    // ---------------- subcycle tracker and bus capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            synced_q      <= 1'b0;
            subcycle_q    <= X3;
            last_addr_q   <= '0;
            last_opcode_q <= '0;
            cycle_count_q <= '0;
            sync_err_q    <= 1'b0;
        end else if (clken_2) begin
            if (ctl.sync) begin
                // A sync anywhere but X3 means we lost alignment: flag it
                // and take this sync as the new cycle start.
                if (synced_q && subcycle_q != X3) sync_err_q <= 1'b1;
                synced_q      <= 1'b1;
                subcycle_q    <= A1;
                cycle_count_q <= cycle_count_q + 32'd1;
            end else if (synced_q) begin
                subcycle_q <= next_subcycle(subcycle_q);
                case (subcycle_q)
                    A1:      last_addr_q[3:0]   <= ctl.dbus;
                    A2:      last_addr_q[7:4]   <= ctl.dbus;
                    A3:      last_addr_q[11:8]  <= ctl.dbus;
                    M1:      last_opcode_q[7:4] <= ctl.dbus;
                    M2:      last_opcode_q[3:0] <= ctl.dbus;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- breakpoint ----------------
`ifdef MCS4_BREAKPOINT_EN
    logic bp_match;

    // The top nibble arrives on the bus at A3; the low byte is already held.
    assign bp_match = clken_2 && !ctl.sync && synced_q && (subcycle_q == A3) &&
                      ctl.bp_en && ({ctl.dbus, last_addr_q[7:0]} == ctl.bp_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             bp_hit_q <= 1'b0;
        else if (bp_match)   bp_hit_q <= 1'b1;   // a new hit beats bp_clr
        else if (ctl.bp_clr) bp_hit_q <= 1'b0;
    end
`else
    logic unused_bp;

    assign bp_hit_q  = 1'b0;
    assign unused_bp = ctl.bp_en ^ ctl.bp_clr ^ (^ctl.bp_addr);
`endif

    // ---------------- outputs ----------------
    assign ctl.clken_1     = clken_1;
    assign ctl.clken_2     = clken_2;
    assign ctl.halted      = halted;
    assign ctl.synced      = synced_q;
    assign ctl.subcycle    = subcycle_q;
    assign ctl.last_addr   = last_addr_q;
    assign ctl.last_opcode = last_opcode_q;
    assign ctl.cycle_count = cycle_count_q;
    assign ctl.bp_hit      = bp_hit_q;
    assign ctl.sync_err    = sync_err_q;
    assign ctl.run_state   = state_q;

endmodule

// File: doc/mcs4_run_ctrl.md
# mcs4_run_ctrl

Run/step controller and two-phase clock-enable sequencer for the MCS-4 system. Generates `clken_1`/`clken_2` for the i4004, i4001 and i4002. Tracks the 8-subcycle instruction cycle (A1..X3) from the CPU `sync` line and snoops the shared 4-bit data bus to record fetch address and opcode. Gives the PYNQ host run, halt, single-step and an optional address breakpoint, all stopping only on instruction-cycle boundaries.

## Interface
- `CLK_DIV`, 4, clk cycles per phase pulse; legal range 1..255.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; free-run while high.
- `step`  in  1  one-clk pulse; run to the next instruction boundary, then halt.
- `bp_en`  in  1  enable breakpoint compare.
- `bp_addr`  in  12  breakpoint ROM address.
- `bp_clr`  in  1  one-clk pulse; clear `bp_hit`.
- `sync`  in  1  from i4004.
- `dbus`  in  4  OR-combined data bus (`mcs4::char_t`).
- `clken_1`  out  1  phase-1 enable pulse.
- `clken_2`  out  1  phase-2 enable pulse.
- `halted`  out  1  no enables being issued.
- `synced`  out  1  first `sync` seen since reset.
- `subcycle`  out  3  current subcycle (`mcs4::subcycle_t`).
- `last_addr`  out  12  address from the last A1–A3.
- `last_opcode`  out  8  OPR:OPA from the last M1–M2.
- `cycle_count`  out  32  completed instruction cycles.
- `bp_hit`  out  1  sticky breakpoint flag.
- `sync_err`  out  1  sticky; `sync` seen outside X3.

## Operation
- Reset values:
  - `halted`=1; all other outputs 0.
  - `subcycle`=X3 (7), so the first subcycle after the first `sync` is A1.
- Phase generator:
  - Runs only while `halted`=0.
  - Counter counts 0..CLK_DIV-1; at CLK_DIV-1 it emits a one-clk pulse, then wraps.
  - Pulses strictly alternate `clken_1`, `clken_2`, starting with `clken_1`. They are never high together.
  - Subcycle = one `clken_1` pulse + one `clken_2` pulse = 2*CLK_DIV clk.
- All sampling of `sync`/`dbus` happens in the clk where `clken_2`=1.
- Subcycle tracking:
  - `sync`=1 at a `clken_2` defines a boundary: `synced`←1, `subcycle`←A1, `cycle_count`+1 (wraps at 2^32).
  - If `sync`=1 while `synced`=1 and `subcycle`≠X3, `sync_err`←1 and the tracker resyncs to A1.
  - Otherwise, if `synced`, `subcycle` increments mod 8.
- Capture (only when `synced`):
  - `dbus` at A1 → `last_addr[3:0]`, A2 → `[7:4]`, A3 → `[11:8]`.
  - M1 → `last_opcode[7:4]`, M2 → `[3:0]`.
- Run states:
  - HALTED: leave on `run`=1 with `bp_hit`=0, or on a `step` pulse. Going to RUN or STEP, the phase counter clears to 0.
  - RUN: at a boundary, go to HALTED if `run`=0 or `bp_hit`=1.
  - STEP: at the next boundary, go to HALTED.
- Before `synced`, the first `sync` is the boundary. A step from reset therefore runs until the CPU's first `sync`.
- Stops happen only at boundaries. Deasserting `run` mid-cycle finishes the cycle.
- Simultaneous events:
  - `run`=1 with `step`: `run` wins.
  - `step` while RUN/STEP: ignored.
  - `bp_clr` with a new hit in the same clk: the hit wins.
  - `step` while `bp_hit`=1: honoured. `run` while `bp_hit`=1: ignored.
- Reset mid-cycle forces reset values immediately; no partial pulse completes.

## Timing
- From HALTED, `run` sampled high in clk t:
  - `halted`=0 at t+1.
  - First `clken_1` at t+CLK_DIV.
  - First `clken_2` at t+2*CLK_DIV.
- Halt latency: boundary `clken_2` in clk t → `halted`=1 at t+1, no further pulses.
- Captured fields and `cycle_count` update in clk t+1 after the sampling `clken_2`.
- `bp_hit` sets at t+1 after the A3 `clken_2`. The halt takes effect at the next boundary, so the breakpoint instruction's cycle completes.
- CLK_DIV=1: pulses alternate every clk; one subcycle = 2 clk.

## Configuration
- `MCS4_BREAKPOINT_EN` defined:
  - At A3 capture, if `bp_en`=1 and the assembled 12-bit address equals `bp_addr`, `bp_hit`←1.
- Not defined:
  - Compare logic is absent; `bp_hit` is tied 0.
  - `bp_en`, `bp_addr`, `bp_clr` remain ports and are ignored.

## Structure
- Package `mcs4`:
  - `subcycle_t` enum: A1=0, A2, A3, M1, M2, X1, X2, X3=7.
  - `run_state_t` enum: HALTED, RUN, STEP.
  - Existing `char_t`.
- Sub-module `mcs4_phase_gen`:
  - Contents: divider counter, phi toggle.
  - Inputs: `clk`, `rst`, `enable`, `restart`.
  - Outputs: `clken_1`, `clken_2`.

## Test plan
- Reset, CLK_DIV=4, `run`=1 at t:
  - `clken_1` at t+4, `clken_2` at t+8, repeating every 8 clk.
  - Never both high together.
- Bus model:
  - Stimulus: `sync` asserted at X3, dbus A1=0x4, A2=0x2, A3=0x1, M1=0xD, M2=0x5.
  - Expected: `last_addr`=0x124, `last_opcode`=0xD5, `cycle_count` increments once per 8 subcycles.
- Drop `run` during M2:
  - Pulses continue through X3.
  - `halted`=1 one clk after the boundary `clken_2`.
  - `subcycle`=A1.
- From HALTED, one `step` pulse:
  - Exactly 8 `clken_1` and 8 `clken_2` pulses, then halt.
  - `cycle_count` +1.
- With `MCS4_BREAKPOINT_EN`, `bp_en`=1, `bp_addr`=0x124, `run`=1:
  - `bp_hit`=1 after the A3 of that fetch.
  - Halt at the following boundary; `run`=1 does not restart.
  - `bp_clr` restarts.
- `sync` pulsed at M1 while synced:
  - `sync_err`=1, `subcycle`=A1 next.
- `rst` asserted mid-X1:
  - All outputs at reset values in the same clk; `halted`=1.
